csr_file: RTL and testbench

Machine-mode control and status register file that terminates the commit-stage CSR write interface. Each cycle it accepts at most one CSR write or one trap entry from the committer. It serves combinational CSR reads to the dispatch/system path and exports `mtvec`, `mepc` and `mstatus.MIE` to the system unit. Optional 64-bit `mcycle`/`minstret` counters are included.

---
 rtl/csr_file_if.sv | 22 ++
 rtl/csr_file.sv | 230 +++++++++++++++++++++++
 tb/tb_csr_file.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// Commit-stage CSR write interface.
// The committer drives it through the req modport: at most one CSR write or one trap entry per cycle.
// The CSR file receives it through the rsp modport.
// There is no back-pressure, so every cycle in which valid is high is consumed.
interface csr_wif #(
    parameter int XLEN = 32
);
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] cause;
    logic            trap;
    logic            valid;

    modport req (
        output addr, data, pc, cause, trap, valid
    );

    modport rsp (
        input addr, data, pc, cause, trap, valid
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file.
// It accepts CSR writes and trap entries from the commit stage and MRET pulses.
// It serves zero-latency combinational reads to the system path.
// It exports mtvec, mepc and mstatus.MIE to the system unit.
//
// Optional feature macro: CSR_COUNTERS_EN.
// When the macro is defined, the file adds 64-bit mcycle/minstret counters with their
// machine (0xB..) and user read-only (0xC..) addresses.
// Without it, those addresses are unimplemented and retire is ignored.
module csr_file #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic            clk,
    input  logic            rst,
    csr_wif.rsp             wbcsr_wif,
    input  logic            mret,
    input  logic            retire,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_illegal,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            mstatus_mie
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // misa: MXL field for the configured width, with only the base integer ISA (bit 8, 'I') set.
    localparam logic [1:0]      MISA_MXL = (XLEN == 64) ? 2'b10 : 2'b01;
    localparam logic [XLEN-1:0] MISA_VAL = {MISA_MXL, (XLEN-2)'(9'h100)};

    // mtvec is direct mode only, so the reset value has its mode bits cleared.
    localparam logic [XLEN-1:0] MTVEC_RST = {MTVEC_RESET[XLEN-1:2], 2'b00};

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    logic            trap_en;
    logic            wr_en;
    logic            mret_en;
    logic [XLEN-1:0] mstatus_val;

    // The PC is word aligned in mepc, so its low two bits are never stored.
    logic [1:0] unused_pc_bits;
    assign unused_pc_bits = wbcsr_wif.pc[1:0];

    // Resolve the three update sources.
    // A trap takes the strobe away from a CSR write.
    // Any commit strobe suppresses a coincident MRET.
    always_comb begin
        trap_en = wbcsr_wif.valid && wbcsr_wif.trap;
        wr_en   = wbcsr_wif.valid && !wbcsr_wif.trap;
        mret_en = mret && !wbcsr_wif.valid;
    end

    // Assemble the architectural mstatus view.
    // MPP is hardwired to machine mode because this hart has no other privilege level.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mie_q;
        mstatus_val[7]     = mpie_q;
        mstatus_val[12:11] = 2'b11;
    end

    // Main machine-mode state.
    // Trap entry saves the PC and cause and stacks MIE.
    // CSR writes apply their WARL masks.
    // MRET unstacks MIE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_en) begin
            mepc_q   <= {wbcsr_wif.pc[XLEN-1:2], 2'b00};
            mcause_q <= wbcsr_wif.cause;
            mtval_q  <= '0;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (wr_en) begin
            case (wbcsr_wif.addr)
                ADDR_MSTATUS: begin
                    mie_q  <= wbcsr_wif.data[3];
                    mpie_q <= wbcsr_wif.data[7];
                end
                ADDR_MTVEC:    mtvec_q    <= {wbcsr_wif.data[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_q <= wbcsr_wif.data;
                ADDR_MEPC:     mepc_q     <= {wbcsr_wif.data[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_q   <= wbcsr_wif.data;
                ADDR_MTVAL:    mtval_q    <= wbcsr_wif.data;
                default: ;
            endcase
        end else if (mret_en) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end
    end

`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE      = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET    = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH     = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH   = 12'hC82;

    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic [63:0] mcycle_d;
    logic [63:0] minstret_d;

    // Counter next state.
    // The counters normally increment.
    // A write to either half replaces that half, keeps the other half unchanged, and drops the increment.
    // A low-half write therefore never carries into the high half.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, retire};
        if (wr_en) begin
            case (wbcsr_wif.addr)
                ADDR_MCYCLE: begin
                    mcycle_d             = mcycle_q;
                    mcycle_d[XLEN-1:0]   = wbcsr_wif.data;
                end
                ADDR_MINSTRET: begin
                    minstret_d           = minstret_q;
                    minstret_d[XLEN-1:0] = wbcsr_wif.data;
                end
                ADDR_MCYCLEH: begin
                    if (XLEN == 32) begin
                        mcycle_d = {wbcsr_wif.data[31:0], mcycle_q[31:0]};
                    end
                end
                ADDR_MINSTRETH: begin
                    if (XLEN == 32) begin
                        minstret_d = {wbcsr_wif.data[31:0], minstret_q[31:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter registers, cleared by reset and otherwise advanced every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    // Without counters there is nothing to count retirements with.
    logic unused_retire;
    assign unused_retire = retire;
`endif

    // Combinational read port.
    // It shows register state only; a same-cycle write is not bypassed.
    // Unknown addresses read as zero and are flagged as illegal.
    always_comb begin
        rd_data    = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            ADDR_MSTATUS:   rd_data = mstatus_val;
            ADDR_MISA:      rd_data = MISA_VAL;
            ADDR_MTVEC:     rd_data = mtvec_q;
            ADDR_MSCRATCH:  rd_data = mscratch_q;
            ADDR_MEPC:      rd_data = mepc_q;
            ADDR_MCAUSE:    rd_data = mcause_q;
            ADDR_MTVAL:     rd_data = mtval_q;
            ADDR_MVENDORID: rd_data = '0;
            ADDR_MARCHID:   rd_data = '0;
            ADDR_MIMPID:    rd_data = '0;
            ADDR_MHARTID:   rd_data = HART_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,   ADDR_CYCLE:   rd_data = mcycle_q[XLEN-1:0];
            ADDR_MINSTRET, ADDR_INSTRET: rd_data = minstret_q[XLEN-1:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH: begin
                if (XLEN == 32) begin
                    rd_data = XLEN'(mcycle_q[63:32]);
                end else begin
                    rd_illegal = 1'b1;
                end
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                if (XLEN == 32) begin
                    rd_data = XLEN'(minstret_q[63:32]);
                end else begin
                    rd_illegal = 1'b1;
                end
            end
`endif
            default:        rd_illegal = 1'b1;
        endcase
    end

    // Exported state for the system unit.
    always_comb begin
        mtvec       = mtvec_q;
        mepc        = mepc_q;
        mstatus_mie = mie_q;
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file.
// It covers reset values, WARL write masks, trap entry, MRET, and the priority between them.
// It also covers unimplemented addresses and asynchronous reset during a write.
// When CSR_COUNTERS_EN is defined, it also covers the counters.
module tb_csr_file;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            mret;
    logic            retire;
    logic [11:0]     rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_illegal;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            mstatus_mie;

    int tests;
    int failed;

    csr_wif #(.XLEN(XLEN)) wif ();

    csr_file #(
        .XLEN        (XLEN),
        .MTVEC_RESET (32'h8000_0000),
        .HART_ID     (32'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wbcsr_wif   (wif),
        .mret        (mret),
        .retire      (retire),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_illegal  (rd_illegal),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .mstatus_mie (mstatus_mie)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count the outcome.
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one commit-stage cycle, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic valid, input logic trap, input logic [11:0] addr,
                                 input logic [XLEN-1:0] data, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] cause, input logic mret_in);
        wif.valid = valid;
        wif.trap  = trap;
        wif.addr  = addr;
        wif.data  = data;
        wif.pc    = pc;
        wif.cause = cause;
        mret      = mret_in;
        @(posedge clk);
        #1;
        wif.valid = 1'b0;
        wif.trap  = 1'b0;
        mret      = 1'b0;
    endtask

    // Present a read address and check the combinational read data.
    task automatic readCheck(input string tag, input logic [11:0] addr,
                             input logic [XLEN-1:0] expected);
        rd_addr = addr;
        #1;
        checkOutput(tag, rd_data, expected);
    endtask

    // Present a read address and check the illegal-address flag.
    task automatic illegalCheck(input string tag, input logic [11:0] addr, input logic expected);
        rd_addr = addr;
        #1;
        checkOutput(tag, {31'd0, rd_illegal}, {31'd0, expected});
    endtask

    // Directed sequence of steps.
    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        mret      = 1'b0;
        retire    = 1'b0;
        rd_addr   = 12'h000;
        wif.valid = 1'b0;
        wif.trap  = 1'b0;
        wif.addr  = 12'h000;
        wif.data  = '0;
        wif.pc    = '0;
        wif.cause = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values.
        readCheck("rst_mtvec", 12'h305, 32'h8000_0000);
        illegalCheck("rst_mtvec_legal", 12'h305, 1'b0);
        readCheck("rst_mstatus", 12'h300, 32'h0000_1800);
        readCheck("rst_mepc", 12'h341, 32'h0);
        readCheck("rst_mcause", 12'h342, 32'h0);
        readCheck("rst_mscratch", 12'h340, 32'h0);
        readCheck("rst_mhartid", 12'hF14, 32'd3);
        readCheck("rst_misa", 12'h301, 32'h4000_0100);
        readCheck("rst_mvendorid", 12'hF11, 32'h0);
        checkOutput("rst_mtvec_out", mtvec, 32'h8000_0000);
        checkOutput("rst_mie_out", {31'd0, mstatus_mie}, 32'd0);

        // WARL masks and read-only registers.
        applyStimulus(1'b1, 1'b0, 12'h305, 32'h1234_5677, '0, '0, 1'b0);
        readCheck("mtvec_warl", 12'h305, 32'h1234_5674);
        checkOutput("mtvec_out", mtvec, 32'h1234_5674);
        applyStimulus(1'b1, 1'b0, 12'hF14, 32'd5, '0, '0, 1'b0);
        readCheck("mhartid_ro", 12'hF14, 32'd3);
        applyStimulus(1'b1, 1'b0, 12'h301, 32'h0, '0, '0, 1'b0);
        readCheck("misa_ro", 12'h301, 32'h4000_0100);
        applyStimulus(1'b1, 1'b0, 12'h341, 32'h1234_5677, '0, '0, 1'b0);
        readCheck("mepc_warl", 12'h341, 32'h1234_5674);
        applyStimulus(1'b1, 1'b0, 12'h342, 32'h8000_0007, '0, '0, 1'b0);
        readCheck("mcause_wr", 12'h342, 32'h8000_0007);
        applyStimulus(1'b1, 1'b0, 12'h343, 32'h0000_DEAD, '0, '0, 1'b0);
        readCheck("mtval_wr", 12'h343, 32'h0000_DEAD);

        // Set MIE, then take a trap; the trap ignores addr/data.
        applyStimulus(1'b1, 1'b0, 12'h300, 32'h0000_0008, '0, '0, 1'b0);
        readCheck("mstatus_mie_set", 12'h300, 32'h0000_1808);
        checkOutput("mie_out_set", {31'd0, mstatus_mie}, 32'd1);
        applyStimulus(1'b1, 1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_0103, 32'd2, 1'b0);
        checkOutput("trap_mepc_out", mepc, 32'h0000_0100);
        readCheck("trap_mepc", 12'h341, 32'h0000_0100);
        readCheck("trap_mcause", 12'h342, 32'd2);
        readCheck("trap_mtval", 12'h343, 32'h0);
        readCheck("trap_mstatus", 12'h300, 32'h0000_1880);
        checkOutput("trap_mie_out", {31'd0, mstatus_mie}, 32'd0);

        // MRET restores MIE from MPIE and sets MPIE.
        applyStimulus(1'b0, 1'b0, 12'h000, '0, '0, '0, 1'b1);
        checkOutput("mret_mie_out", {31'd0, mstatus_mie}, 32'd1);
        readCheck("mret_mstatus", 12'h300, 32'h0000_1888);

        // A trap together with MRET: only the trap takes effect.
        applyStimulus(1'b1, 1'b1, 12'h000, '0, 32'h0000_0208, 32'h0000_000B, 1'b1);
        checkOutput("trapmret_mie_out", {31'd0, mstatus_mie}, 32'd0);
        readCheck("trapmret_mstatus", 12'h300, 32'h0000_1880);
        readCheck("trapmret_mepc", 12'h341, 32'h0000_0208);
        readCheck("trapmret_mcause", 12'h342, 32'h0000_000B);

        // A CSR write together with MRET: the write lands and MRET is ignored.
        applyStimulus(1'b1, 1'b0, 12'h300, 32'h0, '0, '0, 1'b0);
        readCheck("mstatus_clear", 12'h300, 32'h0000_1800);
        applyStimulus(1'b1, 1'b0, 12'h340, 32'h0000_0ABC, '0, '0, 1'b1);
        readCheck("wrmret_mscratch", 12'h340, 32'h0000_0ABC);
        readCheck("wrmret_mstatus", 12'h300, 32'h0000_1800);

        // Unimplemented address: reads as zero and is flagged; a write to it changes nothing.
        readCheck("unimpl_data", 12'h7C0, 32'h0);
        illegalCheck("unimpl_flag", 12'h7C0, 1'b1);
        applyStimulus(1'b1, 1'b0, 12'h7C0, 32'hFFFF_FFFF, '0, '0, 1'b0);
        readCheck("unimpl_wr_mtvec", 12'h305, 32'h1234_5674);
        readCheck("unimpl_wr_mscratch", 12'h340, 32'h0000_0ABC);
        readCheck("unimpl_wr_mepc", 12'h341, 32'h0000_0208);
        readCheck("unimpl_wr_mcause", 12'h342, 32'h0000_000B);
        readCheck("unimpl_wr_mstatus", 12'h300, 32'h0000_1800);

`ifdef CSR_COUNTERS_EN
        // Counters: retire high for 10 cycles, then preload mcycle to force a carry into the high half.
        applyStimulus(1'b1, 1'b0, 12'hB02, 32'h0, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'hB82, 32'h0, '0, '0, 1'b0);
        retire = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        retire = 1'b0;
        readCheck("minstret_10", 12'hB02, 32'd10);
        readCheck("instret_alias", 12'hC02, 32'd10);
        readCheck("minstreth_0", 12'hB82, 32'd0);
        applyStimulus(1'b1, 1'b0, 12'hB80, 32'h0, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'hB00, 32'hFFFF_FFFF, '0, '0, 1'b0);
        readCheck("mcycle_preload", 12'hB00, 32'hFFFF_FFFF);
        readCheck("mcycleh_preload", 12'hB80, 32'h0);
        @(posedge clk);
        #1;
        readCheck("mcycle_wrap_lo", 12'hB00, 32'h0);
        readCheck("mcycle_wrap_hi", 12'hB80, 32'h1);
        readCheck("cycleh_alias", 12'hC80, 32'h1);
        retire = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'hB02, 32'd100, '0, '0, 1'b0);
        retire = 1'b0;
        readCheck("minstret_wr_wins", 12'hB02, 32'd100);
`else
        // Without counters, the counter addresses are unimplemented.
        readCheck("nocnt_data", 12'hB00, 32'h0);
        illegalCheck("nocnt_flag", 12'hB00, 1'b1);
        illegalCheck("nocnt_alias_flag", 12'hC00, 1'b1);
`endif

        // Asynchronous reset asserted while a write is being presented discards that write.
        wif.valid = 1'b1;
        wif.trap  = 1'b0;
        wif.addr  = 12'h340;
        wif.data  = 32'h0000_0055;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        wif.valid = 1'b0;
        rst       = 1'b0;
        readCheck("midrst_mscratch", 12'h340, 32'h0);
        readCheck("midrst_mtvec", 12'h305, 32'h8000_0000);
        readCheck("midrst_mepc", 12'h341, 32'h0);
        readCheck("midrst_mstatus", 12'h300, 32'h0000_1800);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
